// File: rtl/eth_tx_fifo_pkg.sv
// Shared types and constants for the Ethernet transmit frame FIFO.
package eth_tx_fifo_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = 9;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wr_state_e;

  // One stored byte together with its end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/eth_tx_frame_fifo_if.sv
// Byte-wide AXI-Stream link used on both sides of the transmit frame FIFO.
interface eth_tx_frame_fifo_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/eth_tx_fifo_ram.sv
// Simple dual-port frame storage: one write port, one registered read port.
module eth_tx_fifo_ram
  import eth_tx_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  tx_clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  entry_t                wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output entry_t                rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  entry_t mem [DEPTH];

  // Write port.
  always_ff @(posedge tx_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; data appears the cycle after re.
  always_ff @(posedge tx_clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward transmit frame buffer: frames are released to the MAC only
// once complete, and bad or oversize frames are discarded whole.
module eth_tx_frame_fifo
  import eth_tx_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst_n,
  eth_tx_frame_fifo_if.slave    s_axis,
  eth_tx_frame_fifo_if.master   m_axis,
  output logic                  drop_bad,
  output logic                  drop_full,
  output logic [ADDR_WIDTH:0]   frame_count
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_e        state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_commit;
  logic [PTR_W-1:0] rd_ptr;
  logic             s_ready;

  logic             accept;
  logic             full;
  logic             we;
  logic             commit;
  entry_t           wentry;

  entry_t           ram_q;
  entry_t           sk0;
  entry_t           sk1;
  logic [1:0]       cnt;
  logic             pend;

  entry_t           head;
  entry_t           lst0;
  entry_t           lst1;
  entry_t           sk0_n;
  entry_t           sk1_n;
  logic             out_valid;
  logic             pop;
  logic             send_last;
  logic [2:0]       occ_next;
  logic             issue;

  assign s_axis.tready = s_ready;

  // Full compares against the read pointer before this cycle's read.
  assign accept = s_axis.tvalid && s_ready;
  assign full   = (wr_ptr - rd_ptr) == DEPTH_P;
  assign we     = accept && (state == WRITE) && !full;
  assign commit = we && s_axis.tlast && !s_axis.tuser;
  assign wentry = {s_axis.tlast, s_axis.tdata};

  // Write-side FSM: store, commit, or roll back the frame being received.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state     <= WRITE;
      wr_ptr    <= '0;
      wr_commit <= '0;
      s_ready   <= 1'b0;
      drop_bad  <= 1'b0;
      drop_full <= 1'b0;
    end else begin
      s_ready   <= 1'b1;
      drop_bad  <= 1'b0;
      drop_full <= 1'b0;
      case (state)
        WRITE: begin
          if (accept) begin
            if (full) begin
              wr_ptr    <= wr_commit;
              drop_full <= 1'b1;
              if (!s_axis.tlast) state <= DROP;
            end else if (s_axis.tlast && s_axis.tuser) begin
              wr_ptr   <= wr_commit;
              drop_bad <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
              if (s_axis.tlast) wr_commit <= wr_ptr + PTR_W'(1);
            end
          end
        end
        DROP: begin
          if (accept && s_axis.tlast) state <= WRITE;
        end
        default: state <= WRITE;
      endcase
    end
  end

  // Output view: skid entries first, then the RAM output register if it holds a byte.
  always_comb begin
    out_valid = (cnt != 2'd0) || pend;
    head      = (cnt != 2'd0) ? sk0 : ram_q;
    pop       = out_valid && m_axis.tready;
    send_last = pop && head.last;
    lst0      = (cnt != 2'd0) ? sk0 : ram_q;
    lst1      = (cnt == 2'd2) ? sk1 : ram_q;
    sk0_n     = pop ? lst1 : lst0;
    sk1_n     = pop ? ram_q : lst1;
    occ_next  = 3'(cnt) + 3'(pend) - 3'(pop);
    issue     = (rd_ptr != wr_commit) && (occ_next <= 3'd1);
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_valid ? head.data : 8'h00;
  assign m_axis.tlast  = out_valid && head.last;
  assign m_axis.tuser  = 1'b0;

  // Read pointer and skid buffer; reads run ahead only while the skid has room.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      rd_ptr <= '0;
      cnt    <= 2'd0;
      pend   <= 1'b0;
      sk0    <= '0;
      sk1    <= '0;
    end else begin
      cnt  <= 2'(occ_next);
      pend <= issue;
      sk0  <= sk0_n;
      sk1  <= sk1_n;
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Committed-frame count; a commit and an outgoing tlast cancel out.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      frame_count <= '0;
    end else if (commit && !send_last) begin
      frame_count <= frame_count + PTR_W'(1);
    end else if (!commit && send_last) begin
      frame_count <= frame_count - PTR_W'(1);
    end
  end

  eth_tx_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .tx_clk (tx_clk),
    .we     (we),
    .waddr  (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata  (wentry),
    .re     (issue),
    .raddr  (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata  (ram_q)
  );

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Scoreboard bench for eth_tx_frame_fifo: a 2048-byte instance for the main
// scenarios and a 64-byte instance for overflow.
module tb_eth_tx_frame_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_tx_frame_fifo_if sb ();
  eth_tx_frame_fifo_if mb ();
  eth_tx_frame_fifo_if ss ();
  eth_tx_frame_fifo_if ms ();

  logic        db_b, df_b, db_s, df_s;
  logic [11:0] fc_b;
  logic [6:0]  fc_s;

  eth_tx_frame_fifo #(.ADDR_WIDTH(11)) u_big (
    .tx_clk(clk), .tx_rst_n(rst_n), .s_axis(sb), .m_axis(mb),
    .drop_bad(db_b), .drop_full(df_b), .frame_count(fc_b)
  );

  eth_tx_frame_fifo #(.ADDR_WIDTH(6)) u_small (
    .tx_clk(clk), .tx_rst_n(rst_n), .s_axis(ss), .m_axis(ms),
    .drop_bad(db_s), .drop_full(df_s), .frame_count(fc_s)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] exp_b[$];
  logic [8:0] exp_s[$];
  int bad_cnt_b = 0;
  int full_cnt_s = 0;
  int last_cnt_b = 0;
  int fc_peak = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_out = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the large instance: pops expected bytes on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) chk("stable_b", 32'({mb.tvalid, mb.tlast, mb.tdata}), 32'({1'b1, prev_out}));
      if (mb.tvalid && mb.tready) begin
        if (exp_b.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_b: got 0x%0h, expected no byte at %0t", {mb.tlast, mb.tdata}, $time);
        end else begin
          chk("data_b", 32'({mb.tlast, mb.tdata}), 32'(exp_b.pop_front()));
        end
        if (mb.tlast) last_cnt_b++;
      end
      prev_stall = mb.tvalid && !mb.tready;
      prev_out   = {mb.tlast, mb.tdata};
      if (db_b) bad_cnt_b++;
      if (int'(fc_b) > fc_peak) fc_peak = int'(fc_b);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Monitor for the small instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ms.tvalid && ms.tready) begin
        if (exp_s.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_s: got 0x%0h, expected no byte at %0t", {ms.tlast, ms.tdata}, $time);
        end else begin
          chk("data_s", 32'({ms.tlast, ms.tdata}), 32'(exp_s.pop_front()));
        end
      end
      if (df_s) full_cnt_s++;
    end
  end

  task automatic beat_b(input logic [7:0] d, input logic last, input logic user);
    sb.tvalid = 1'b1; sb.tdata = d; sb.tlast = last; sb.tuser = user;
    @(posedge clk); #1;
  endtask

  task automatic idle_b();
    sb.tvalid = 1'b0; sb.tlast = 1'b0; sb.tuser = 1'b0;
  endtask

  task automatic frame_b(input int len, input int base, input logic bad);
    for (int i = 0; i < len; i++) begin
      if (!bad) exp_b.push_back({1'(i == len - 1), 8'(base + i)});
      beat_b(8'(base + i), 1'(i == len - 1), bad && (i == len - 1));
    end
    idle_b();
  endtask

  task automatic beat_s(input logic [7:0] d, input logic last);
    ss.tvalid = 1'b1; ss.tdata = d; ss.tlast = last; ss.tuser = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame_s(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      exp_s.push_back({1'(i == len - 1), 8'(base + i)});
      beat_s(8'(base + i), 1'(i == len - 1));
    end
    ss.tvalid = 1'b0; ss.tlast = 1'b0;
  endtask

  task automatic wait_empty_b(input string name);
    int k = 0;
    while (exp_b.size() != 0 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 32'(exp_b.size()), 32'd0);
  endtask

  task automatic wait_empty_s(input string name);
    int k = 0;
    while (exp_s.size() != 0 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 32'(exp_s.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
    int b0;
    int l0;
    int f0;
    sb.tvalid = 1'b0; sb.tdata = '0; sb.tlast = 1'b0; sb.tuser = 1'b0;
    ss.tvalid = 1'b0; ss.tdata = '0; ss.tlast = 1'b0; ss.tuser = 1'b0;
    mb.tready = 1'b1;
    ms.tready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(sb.tready), 32'd0);
    chk("rst_m_valid", 32'(mb.tvalid), 32'd0);
    chk("rst_m_data", 32'(mb.tdata), 32'd0);
    chk("rst_m_last", 32'(mb.tlast), 32'd0);
    chk("rst_m_user", 32'(mb.tuser), 32'd0);
    chk("rst_drops", 32'({db_b, df_b}), 32'd0);
    chk("rst_fc", 32'(fc_b), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s_ready_up", 32'(sb.tready), 32'd1);

    // Single 64-byte frame: latency 2, contiguous output, count 0->1->0
    frame_b(64, 0, 1'b0);
    chk("fc_commit", 32'(fc_b), 32'd1);
    @(negedge clk);
    chk("lat_n1", 32'(mb.tvalid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2", 32'(mb.tvalid), 32'd1);
    gaps = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!mb.tvalid) gaps++;
      @(posedge clk); #1;
    end
    chk("gaps", 32'(gaps), 32'd0);
    chk("fc_sent", 32'(fc_b), 32'd0);
    chk("idle_after", 32'(mb.tvalid), 32'd0);
    wait_empty_b("drain_single");

    // Bad frame followed by a good one
    fc_peak = 0;
    b0 = bad_cnt_b;
    frame_b(20, 8'hA0, 1'b1);
    frame_b(10, 8'h10, 1'b0);
    wait_empty_b("drain_bad");
    repeat (3) @(posedge clk);
    #1;
    chk("drop_bad_cnt", 32'(bad_cnt_b - b0), 32'd1);
    chk("fc_peak", 32'(fc_peak), 32'd1);
    chk("fc_bad_end", 32'(fc_b), 32'd0);

    // Back-pressure: ready toggling over three back-to-back frames
    l0 = last_cnt_b;
    fork
      begin
        for (int k = 0; k < 3; k++) frame_b(60, k * 60, 1'b0);
      end
      begin
        repeat (500) begin
          mb.tready = ~mb.tready;
          @(posedge clk); #1;
        end
      end
    join
    mb.tready = 1'b1;
    wait_empty_b("drain_bp");
    chk("tlast_cnt", 32'(last_cnt_b - l0), 32'd3);
    chk("fc_bp_end", 32'(fc_b), 32'd0);

    // Commit in the same cycle as an outgoing tlast handshake
    mb.tready = 1'b0;
    frame_b(1, 8'hC0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("fc_hold_a", 32'(fc_b), 32'd1);
    for (int i = 0; i < 3; i++) begin
      exp_b.push_back({1'b0, 8'(8'hD0 + i)});
      beat_b(8'(8'hD0 + i), 1'b0, 1'b0);
    end
    exp_b.push_back({1'b1, 8'hD3});
    mb.tready = 1'b1;
    @(negedge clk);
    chk("pre_simul_out", 32'({mb.tvalid, mb.tlast}), 32'd3);
    beat_b(8'hD3, 1'b1, 1'b0);
    idle_b();
    chk("fc_simul", 32'(fc_b), 32'd1);
    wait_empty_b("drain_simul");
    repeat (2) @(posedge clk);
    #1;
    chk("fc_simul_end", 32'(fc_b), 32'd0);

    // Overflow on the 64-byte instance
    f0 = full_cnt_s;
    ms.tready = 1'b0;
    frame_s(40, 0);
    for (int i = 0; i < 30; i++) begin
      if (i == 25) chk("no_early_full", 32'(full_cnt_s - f0), 32'd0);
      beat_s(8'(100 + i), 1'(i == 29));
    end
    ss.tvalid = 1'b0; ss.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drop_full_cnt", 32'(full_cnt_s - f0), 32'd1);
    chk("fc_s_held", 32'(fc_s), 32'd1);
    ms.tready = 1'b1;
    wait_empty_s("drain_ovf");
    repeat (3) @(posedge clk);
    #1;
    chk("fc_s_empty", 32'(fc_s), 32'd0);
    chk("s_valid_empty", 32'(ms.tvalid), 32'd0);
    frame_s(5, 8'hE0);
    wait_empty_s("drain_after_ovf");

    // Reset while a frame is leaving and another is arriving
    mb.tready = 1'b1;
    frame_b(64, 8'h40, 1'b0);
    for (int i = 0; i < 8; i++) beat_b(8'(8'h90 + i), 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(mb.tvalid), 32'd1);
    @(posedge clk); #1;
    idle_b();
    rst_n = 1'b0;
    #1;
    chk("mrst_m_valid", 32'(mb.tvalid), 32'd0);
    chk("mrst_m_data", 32'(mb.tdata), 32'd0);
    chk("mrst_m_last", 32'(mb.tlast), 32'd0);
    chk("mrst_s_ready", 32'(sb.tready), 32'd0);
    chk("mrst_fc", 32'(fc_b), 32'd0);
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s_ready_again", 32'(sb.tready), 32'd1);
    frame_b(64, 8'h20, 1'b0);
    wait_empty_b("drain_post_rst");
    repeat (2) @(posedge clk);
    #1;
    chk("fc_post_rst", 32'(fc_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_fifo.md
# eth_tx_frame_fifo

Store-and-forward transmit frame buffer in the MAC transmit clock domain, directly upstream of the 1G RGMII MAC's `tx_axis_*` input. It accepts byte-wide AXI-Stream frames, holds each frame until its last byte has arrived, and only then streams it to the MAC without gaps. The MAC therefore never sees a mid-frame underflow. Frames flagged bad by the source, or frames that overflow the buffer, are discarded whole and never reach the MAC.

## Interface
- `ADDR_WIDTH`, 11 — buffer depth is 2^ADDR_WIDTH bytes (default 2048, enough for one 1518-byte frame plus a following frame).
- `tx_clk` input 1 — single clock; same clock as the MAC transmit side.
- `tx_rst_n` input 1 — reset, asynchronous, active-low.
- `s_axis_tdata` input 8 — byte from the frame source.
- `s_axis_tvalid` input 1 — source byte valid.
- `s_axis_tready` output 1 — always 1 outside reset; the block never back-pressures the source and drops instead.
- `s_axis_tlast` input 1 — last byte of the frame.
- `s_axis_tuser` input 1 — sampled on the tlast beat only; 1 marks the frame bad.
- `m_axis_tdata` output 8 — byte to the MAC (`tx_axis_tdata`).
- `m_axis_tvalid` output 1 — byte valid to the MAC.
- `m_axis_tready` input 1 — MAC ready.
- `m_axis_tlast` output 1 — last byte of the frame.
- `m_axis_tuser` output 1 — constant 0.
- `drop_bad` output 1 — one-cycle pulse: a frame was discarded because of tuser.
- `drop_full` output 1 — one-cycle pulse: a frame was discarded because of overflow.
- `frame_count` output ADDR_WIDTH+1 — number of complete frames committed and not yet fully sent.

## Operation
- **Storage:** 2^ADDR_WIDTH × 9-bit RAM, holding {tlast, data}.
- **Pointers:** `wr_ptr`, `wr_commit`, and `rd_ptr`, each ADDR_WIDTH+1 bits and wrapping modulo 2^(ADDR_WIDTH+1).
- **Full:** `wr_ptr - rd_ptr == 2^ADDR_WIDTH`.
- **Write FSM states:**
  - WRITE (reset state): each accepted beat is written at `wr_ptr`, then `wr_ptr` increments.
  - On a tlast beat with tuser=0: `wr_commit <= wr_ptr+1` and `frame_count` increments.
  - On a tlast beat with tuser=1: `wr_ptr <= wr_commit`, `drop_bad` pulses, and the state stays WRITE.
  - Beat arrives while full: the beat is not written, `wr_ptr <= wr_commit`, and `drop_full` pulses.
    - If that beat has tlast, the state stays WRITE.
    - Otherwise the state goes to DROP.
  - DROP: all beats are discarded. On the tlast beat the state returns to WRITE, and there is no further pulse.
- **Read side:**
  - Reads are issued only while `rd_ptr != wr_commit`, so uncommitted bytes are never read.
  - The RAM read has 1-cycle latency and feeds a 2-entry output skid buffer.
  - A read is issued when the skid buffer will have space, which sustains 1 byte/cycle with `m_axis_tready` held high.
  - The output presents the skid head. Frames go out back-to-back, with no idle cycle between them.
- **frame_count:** decrements on an m-side handshake with tlast=1. If a commit and such a handshake happen in the same cycle, the count is unchanged.

## Timing
- **Reset values:**
  - `s_axis_tready=0` during reset, 1 from the first cycle after deassertion.
  - `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `m_axis_tuser=0`.
  - `drop_bad=0`, `drop_full=0`, `frame_count=0`.
  - All pointers 0; state WRITE.
  - Any partial or committed frames are lost.
- **Latency:** with the buffer empty, the committing tlast beat is accepted in cycle N and the first byte shows `m_axis_tvalid=1` in cycle N+2.
- **Output stability:** while `m_axis_tvalid=1 && !m_axis_tready`, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` hold stable.
- **Throughput:** 1 byte/cycle on each side.
- **Bound:** `frame_count ≤ 2^ADDR_WIDTH`.
- **Frame size limit:** a frame longer than 2^ADDR_WIDTH bytes always takes the `drop_full` path.
- **Full condition:** evaluated with the same-cycle read; a read that frees a slot in cycle N does not make room for the write in cycle N.

## Structure
- Shared package `eth_tx_fifo_pkg`:
  - state enum `{WRITE, DROP}`;
  - RAM entry width constant (9).
- One sub-module `eth_tx_fifo_ram`: simple dual-port RAM with one write port and one registered read port, both on `tx_clk`, with no reset on the array.
- The FSM, pointers and skid buffer live in the top module.

## Test plan
- **Single frame:** a 64-byte frame (0x00..0x3F, tlast on 0x3F, tuser=0) with `m_axis_tready=1` → `m_axis_tvalid` rises 2 cycles after tlast; 64 contiguous bytes 0x00..0x3F come out with tlast on 0x3F; `frame_count` goes 0→1→0.
- **Bad frame:** a 20-byte frame with tuser=1 on tlast, followed by a good 10-byte frame → one `drop_bad` pulse; only the 10-byte frame appears; `frame_count` peaks at 1.
- **Overflow:** `ADDR_WIDTH=6`, `m_axis_tready=0`, a 40-byte good frame then a 30-byte frame → the second frame overflows at its 25th byte; one `drop_full` pulse; after `m_axis_tready=1` only the 40-byte frame is output, and the FIFO is empty afterwards.
- **Back-pressure:** `m_axis_tready` toggling 1010… during three back-to-back 60-byte frames → byte order is preserved with no duplicates or gaps; the tlast count equals 3.
- **Simultaneous commit and send:** a commit in the same cycle as an outgoing tlast handshake → `frame_count` is unchanged that cycle.
- **Reset mid-operation:** `tx_rst_n` pulled low mid-frame while output is in progress → all outputs take their reset values immediately; after release, a new 64-byte frame passes correctly.
